// File: rtl/cache_def.sv
// -----------------------------------------------------------------------------
// cache_def
//
// Purpose:
//   Types and constants shared by the direct-mapped cache and its main-memory
//   responder. These include the request/response structs on the
//   cache<->memory link, the line geometry, the responder state encoding, and
//   the power-up image of the backing store.
//
// Contents:
//   LINE_W, WORD_W, ADDR_W, OFFSET_W, WORDS_PER_LINE  line geometry
//   mem_req_type         cache -> memory: addr, data, rw (1 = write), valid
//   mem_data_type        memory -> cache: data, ready
//   mem_resp_state_type  responder FSM states
//   init_line()          power-up contents of a line, by line index
// -----------------------------------------------------------------------------
package cache_def;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int OFFSET_W       = 4;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } mem_resp_state_type;

  // Power-up image of a line. Each 32-bit word holds its own byte address, so
  // the line at 0x40 reads {0x4C, 0x48, 0x44, 0x40}, with the highest word in
  // the top bits.
  function automatic logic [LINE_W-1:0] init_line(input logic [ADDR_W-1:0] index);
    logic [ADDR_W-1:0] base;
    logic [LINE_W-1:0] line;
    line = '0;
    base = index << OFFSET_W;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      line[w*WORD_W +: WORD_W] = base + ADDR_W'(w * 4);
    end
    return line;
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// -----------------------------------------------------------------------------
// cache_mem_responder_if
//
// Purpose:
//   Bundles the cache<->memory link into one port.
//
// Signals:
//   mem_req   mem_req_type   request from the cache (addr, data, rw, valid)
//   mem_data  mem_data_type  response from memory (data, ready)
//
// Modports:
//   master  cache side: drives mem_req, receives mem_data
//   slave   memory side: receives mem_req, drives mem_data
// -----------------------------------------------------------------------------
interface cache_mem_responder_if;
  import cache_def::*;

  mem_req_type  mem_req;
  mem_data_type mem_data;

  modport master (output mem_req, input  mem_data);
  modport slave  (input  mem_req, output mem_data);

endinterface

// File: rtl/cache_mem_array.sv
// -----------------------------------------------------------------------------
// cache_mem_array
//
// Purpose:
//   Single-port DEPTH x 128-bit backing store with a synchronous read. Its
//   power-up contents are the address pattern produced by init_line().
//
// Parameters:
//   DEPTH    number of lines, power of two, >= 2
//
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   async active-high reset; clears only the read register
//   we       in   write enable; wdata is stored at index on the edge
//   re       in   read enable; the line at index appears on rdata after the edge
//   index    in   line index
//   wdata    in   line to write
//   rdata    out  registered read line; holds its value while re is low
// -----------------------------------------------------------------------------
module cache_mem_array
  import cache_def::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [LINE_W-1:0]        wdata,
  output logic [LINE_W-1:0]        rdata
);

  logic [LINE_W-1:0] store [DEPTH];

  // Each line is stored XOR-ed with its power-up image. The store needs no
  // initial values: a cleared RAM reads back as the address pattern, and any
  // line that has been written reads back exactly as it was written. The
  // encoding is removed on every access, so nothing outside this module sees it.
  always_ff @(posedge clk_i) begin
    if (we) begin
      store[index] <= wdata ^ init_line(32'(index));
    end
  end

  // Read register. It doubles as the RAM output register, so it is only
  // loaded on an enabled read and it keeps the last line otherwise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= store[index] ^ init_line(32'(index));
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
//
// Purpose:
//   Main-memory responder for the direct-mapped cache. It accepts one line
//   request at a time and answers LATENCY cycles after the accept. A read
//   returns the stored line. A write echoes the write line and commits it to
//   the store as the response cycle ends. A one-cycle turnaround (GAP) follows
//   every response, and no request is accepted during it.
//
// Parameters:
//   DEPTH    number of 128-bit lines, power of two, >= 2
//   LATENCY  edges from accept to response, >= 1
//
// Ports:
//   clk_i    in   clock, rising edge
//   reset_i  in   async active-high reset; aborts any transaction in flight
//   mem_bus  slave modport of cache_mem_responder_if
//            mem_req  : addr[4 +: log2(DEPTH)] selects the line; other bits ignored
//            mem_data : ready pulses for one cycle; data holds between responses
// -----------------------------------------------------------------------------
module cache_mem_responder
  import cache_def::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  cache_mem_responder_if.slave  mem_bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_resp_state_type state;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   req_index;
  logic [LINE_W-1:0]  req_data;
  logic               req_rw;

  logic               ready_q;
  logic               echo_sel_q;
  logic [LINE_W-1:0]  echo_q;

  logic [IDX_W-1:0]   live_index;
  logic               accept;
  logic               wait_done;

  logic               array_we;
  logic               array_re;
  logic [IDX_W-1:0]   array_index;
  logic [LINE_W-1:0]  array_rdata;

  logic               unused_addr_bits;

  // The offset bits and the bits above the index are ignored, so addresses
  // beyond the store alias modulo DEPTH.
  assign live_index       = mem_bus.mem_req.addr[OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^mem_bus.mem_req.addr;

  assign accept    = (state == IDLE) && mem_bus.mem_req.valid;
  assign wait_done = (state == BUSY) && (cnt == '0);

  // The single array port is time-shared. A read is launched on the edge that
  // enters RESP, so the line is in the read register for the response cycle.
  // With LATENCY = 1 that edge is the accept edge itself, so the live request
  // address drives the port while the FSM is IDLE. The write commits on the
  // edge that leaves RESP. An async reset during RESP moves the state to IDLE
  // before that edge arrives, so the commit never happens.
  always_comb begin
    array_index = req_index;
    array_re    = 1'b0;
    array_we    = 1'b0;
    if (state == IDLE) begin
      array_index = live_index;
      array_re    = (LATENCY == 1) && accept && !mem_bus.mem_req.rw;
    end else if (wait_done) begin
      array_re    = !req_rw;
    end else if (state == RESP) begin
      array_we    = req_rw;
    end
  end

  // Transaction FSM with the latency counter, request capture and response
  // registers. The request is sampled only on the accept edge. The counter
  // runs LATENCY-1 down to 0 and then one more edge moves the FSM into RESP,
  // which puts ready exactly LATENCY edges after the accept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      req_index  <= '0;
      req_data   <= '0;
      req_rw     <= 1'b0;
      ready_q    <= 1'b0;
      echo_sel_q <= 1'b0;
      echo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_bus.mem_req.valid) begin
            req_index <= live_index;
            req_data  <= mem_bus.mem_req.data;
            req_rw    <= mem_bus.mem_req.rw;
            cnt       <= CNT_LOAD;
            if (LATENCY == 1) begin
              state      <= RESP;
              ready_q    <= 1'b1;
              echo_sel_q <= mem_bus.mem_req.rw;
              if (mem_bus.mem_req.rw) begin
                echo_q <= mem_bus.mem_req.data;
              end
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state      <= RESP;
            ready_q    <= 1'b1;
            echo_sel_q <= req_rw;
            if (req_rw) begin
              echo_q <= req_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state   <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  cache_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we      (array_we),
    .re      (array_re),
    .index   (array_index),
    .wdata   (req_data),
    .rdata   (array_rdata)
  );

  // The response line comes either from the array read register or from the
  // echo register. Both registers and the select change only on the edge that
  // enters RESP, so data holds its last value until the next response. There
  // is no combinational path from mem_req.
  assign mem_bus.mem_data = '{data:  (echo_sel_q ? echo_q : array_rdata),
                              ready: ready_q};

endmodule

// File: tb/tb_cache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_responder
//
// Purpose:
//   Directed bench for cache_mem_responder with DEPTH = 1024 and LATENCY = 4.
//   The stimulus pushes each expected response, with the cycle in which it is
//   due, onto a scoreboard queue. A negedge monitor pops an entry for every
//   ready pulse and checks both the data and the arrival cycle.
// -----------------------------------------------------------------------------
module tb_cache_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int LAT    = 4;
  // Accept edge, LAT edges to reach RESP, then RESP and GAP each take one edge.
  localparam int PERIOD = LAT + 3;

  localparam logic [127:0] LINE_40   = {32'h0000004C, 32'h00000048, 32'h00000044, 32'h00000040};
  localparam logic [127:0] LINE_100  = {32'h0000010C, 32'h00000108, 32'h00000104, 32'h00000100};
  localparam logic [127:0] LINE_10   = {32'h0000001C, 32'h00000018, 32'h00000014, 32'h00000010};
  localparam logic [127:0] W_DEAD    = 128'hDEAD0000_11112222_33334444_5555BEEF;
  localparam logic [127:0] W_ALIAS   = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
  localparam logic [127:0] W_ABORT   = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
  localparam logic [127:0] W_IGNORED = 128'h55555555_55555555_55555555_55555555;

  typedef struct {
    logic [127:0] data;
    int           at;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  cache_mem_responder_if bus();

  cache_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .mem_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] d, input int acc);
    exp_t e;
    e.data = d;
    e.at   = acc + LAT;
    exp_q.push_back(e);
  endtask

  // Drives one request and returns the cycle number of its accept edge.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [127:0] data,
                                input logic rw, input bit hold, output int acc);
    @(negedge clk);
    bus.mem_req.addr  = addr;
    bus.mem_req.data  = data;
    bus.mem_req.rw    = rw;
    bus.mem_req.valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) begin
      @(negedge clk);
      bus.mem_req.valid = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s: %0d responses missing after %0d cycles, expected 0 outstanding",
               name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (reset_i === 1'b0 && bus.mem_data.ready !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_ready", 128'(bus.mem_data.ready), 128'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("resp_data", bus.mem_data.data, e.data);
        check_output("resp_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;

    reset_i     = 1'b1;
    bus.mem_req = '0;
    repeat (2) @(negedge clk);
    check_output("reset_ready", 128'(bus.mem_data.ready), 128'd0);
    check_output("reset_data", bus.mem_data.data, 128'd0);
    @(negedge clk);
    reset_i = 1'b0;

    $display("[TB] read of 0x40 from power-up contents");
    apply_stimulus(32'h40, '0, 1'b0, 1'b0, acc);
    push_exp(LINE_40, acc);
    wait_idle("read_0x40");
    check_output("data_hold", bus.mem_data.data, LINE_40);
    check_output("ready_low_after_resp", 128'(bus.mem_data.ready), 128'd0);

    $display("[TB] async reset mid-cycle");
    @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    check_output("async_reset_ready", 128'(bus.mem_data.ready), 128'd0);
    check_output("async_reset_data", bus.mem_data.data, 128'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;

    $display("[TB] write 0x80 then read 0x80 with valid held");
    apply_stimulus(32'h80, W_DEAD, 1'b1, 1'b1, acc);
    push_exp(W_DEAD, acc);
    @(negedge clk);
    bus.mem_req.addr = 32'h80;
    bus.mem_req.rw   = 1'b0;
    bus.mem_req.data = W_IGNORED;
    push_exp(W_DEAD, acc + PERIOD);
    wait_cyc(acc + PERIOD);
    bus.mem_req.valid = 1'b0;
    wait_idle("write_read_0x80");

    $display("[TB] valid held across three transactions");
    apply_stimulus(32'h100, '0, 1'b0, 1'b1, acc);
    for (int k = 0; k < 3; k++) push_exp(LINE_100, acc + k * PERIOD);
    wait_cyc(acc + 2 * PERIOD + 1);
    bus.mem_req.valid = 1'b0;
    wait_idle("held_valid");

    $display("[TB] aliasing write to 0x4000, reads of 0x0 and 0x4010");
    apply_stimulus(32'h4000, W_ALIAS, 1'b1, 1'b0, acc);
    push_exp(W_ALIAS, acc);
    wait_idle("alias_write");
    apply_stimulus(32'h0, '0, 1'b0, 1'b0, acc);
    push_exp(W_ALIAS, acc);
    wait_idle("alias_read_0x0");
    apply_stimulus(32'h4010, '0, 1'b0, 1'b0, acc);
    push_exp(LINE_10, acc);
    wait_idle("alias_read_0x4010");

    $display("[TB] write to 0x0 aborted by reset during the response cycle");
    apply_stimulus(32'h0, W_ABORT, 1'b1, 1'b0, acc);
    wait_cyc(acc + LAT - 1);
    @(posedge clk);
    #1;
    check_output("abort_ready_in_resp", 128'(bus.mem_data.ready), 128'd1);
    #1 reset_i = 1'b1;
    #1;
    check_output("abort_ready", 128'(bus.mem_data.ready), 128'd0);
    check_output("abort_data", bus.mem_data.data, 128'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    apply_stimulus(32'h0, '0, 1'b0, 1'b0, acc);
    push_exp(W_ALIAS, acc);
    wait_idle("read_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
